// File: rtl/wallace_mult_pipe_pkg.sv
// rtl/wallace_mult_pipe_pkg.sv - shared types and sizing helpers for the pipelined Wallace multiplier
// Contents: prod_w(), rows_after(), wallace_levels(), row_pair_t.
package wallace_pkg;

  localparam int MAX_PROD_W = 64;

  // Registered (sum, carry) pair leaving the reduction tree; sized for the widest legal build.
  typedef struct packed {
    logic [MAX_PROD_W-1:0] sum;
    logic [MAX_PROD_W-1:0] carry;
  } row_pair_t;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // Row count left after 'levels' Wallace levels: each triple becomes two rows,
  // and leftover rows (one or two) pass on unchanged in count.
  function automatic int rows_after(input int rows, input int levels);
    int r;
    r = rows;
    for (int i = 0; i < levels; i++) begin
      if (r > 2) r = 2 * (r / 3) + r % 3;
    end
    return r;
  endfunction

  // Number of reduction levels needed to reach two rows (8 rows -> 4 levels).
  function automatic int wallace_levels(input int rows);
    int r;
    int n;
    r = rows;
    n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/wallace_mult_pipe_if.sv
// rtl/wallace_mult_pipe_if.sv - operand/result handshake bundle for wallace_mult_pipe
// Input side: in_valid, in_ready, in_a, in_b, in_tag (+ in_signed with WALLACE_SIGNED_EN).
// Output side: out_valid, out_ready, out_prod, out_tag.
// slave = multiplier side, master = producer/consumer side.
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  import wallace_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_a;
  logic [WIDTH-1:0]           in_b;
  logic [TAG_W-1:0]           in_tag;
`ifdef WALLACE_SIGNED_EN
  logic                       in_signed;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic [prod_w(WIDTH)-1:0]   out_prod;
  logic [TAG_W-1:0]           out_tag;

`ifdef WALLACE_SIGNED_EN
  modport slave  (input  in_valid, in_a, in_b, in_tag, in_signed, out_ready,
                  output in_ready, out_valid, out_prod, out_tag);
  modport master (output in_valid, in_a, in_b, in_tag, in_signed, out_ready,
                  input  in_ready, out_valid, out_prod, out_tag);
`else
  modport slave  (input  in_valid, in_a, in_b, in_tag, out_ready,
                  output in_ready, out_valid, out_prod, out_tag);
  modport master (output in_valid, in_a, in_b, in_tag, out_ready,
                  input  in_ready, out_valid, out_prod, out_tag);
`endif

endinterface

// File: rtl/wallace_csa_row.sv
// rtl/wallace_csa_row.sv - N-bit row of full adders (3:2 carry-save compressor)
// Ports: x, y, z (N-bit rows in), sum (N-bit), carry (N-bit, already shifted up one column).
// Tie z to zero for a half-adder row.
module wallace_csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [N-1:0] maj;
  logic         unused_cout;

  assign sum   = x ^ y ^ z;
  assign maj   = (x & y) | (x & z) | (y & z);
  // The carry out of the top column falls off the product width.
  assign carry = {maj[N-2:0], 1'b0};
  assign unused_cout = maj[N-1];

endmodule

// File: rtl/wallace_mult_pipe.sv
// rtl/wallace_mult_pipe.sv - three-stage elastic Wallace-tree multiplier with tag sideband
// Ports: clk, rst (async, active high), io (wallace_mult_pipe_if.slave).
// S0 holds operands -> partial products; S1 holds reduced (sum, carry); S2 holds out_prod/out_tag.
// Macro WALLACE_SIGNED_EN adds in_signed and Baugh-Wooley two's-complement products.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wallace_mult_pipe_if.slave    io
);

  localparam int PW = prod_w(WIDTH);
`ifdef WALLACE_SIGNED_EN
  // Extra row carries the Baugh-Wooley correction constants.
  localparam int NROWS = WIDTH + 1;
`else
  localparam int NROWS = WIDTH;
`endif
  localparam int LEVELS = wallace_levels(NROWS);

  logic                  v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic                  adv0, adv1, adv2, in_ready, accept;
  logic [WIDTH-1:0]      a0_q, a0_d, b0_q, b0_d;
  logic [TAG_W-1:0]      tag0_q, tag0_d, tag1_q, tag1_d, out_tag_q, out_tag_d;
`ifdef WALLACE_SIGNED_EN
  logic                  sgn0_q, sgn0_d;
`endif
  row_pair_t             pair_q, pair_d;
  logic [PW-1:0]         out_prod_q, out_prod_d, cpa_sum, red_sum, red_carry;
  logic [NROWS*PW-1:0]   pp_flat;
  logic                  rc;
  logic                  unused_pair;

  // Handshake: in_ready depends on stage occupancy and out_ready only, never on in_valid.
  always_comb begin
    adv2     = v2_q & io.out_ready;
    adv1     = v1_q & (~v2_q | adv2);
    adv0     = v0_q & (~v1_q | adv1);
    in_ready = ~v0_q | adv0;
    accept   = io.in_valid & in_ready;
  end

  always_comb begin
    v0_d       = accept | (v0_q & ~adv0);
    v1_d       = adv0 | (v1_q & ~adv1);
    v2_d       = adv1 | (v2_q & ~adv2);
    out_prod_d = adv1 ? cpa_sum : out_prod_q;
    out_tag_d  = adv1 ? tag1_q  : out_tag_q;
  end

  always_comb begin
    a0_d   = accept ? io.in_a   : a0_q;
    b0_d   = accept ? io.in_b   : b0_q;
    tag0_d = accept ? io.in_tag : tag0_q;
`ifdef WALLACE_SIGNED_EN
    sgn0_d = accept ? io.in_signed : sgn0_q;
`endif
    tag1_d = adv0 ? tag0_q : tag1_q;
    pair_d = pair_q;
    if (adv0) begin
      pair_d                 = '0;
      pair_d.sum[PW-1:0]     = red_sum;
      pair_d.carry[PW-1:0]   = red_carry;
    end
  end

  // Partial-product array: row i is a & b[i] placed at column offset i.
  always_comb begin
    pp_flat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
`ifdef WALLACE_SIGNED_EN
        // Terms touching exactly one operand MSB are inverted in signed mode.
        pp_flat[i*PW + i + j] = (a0_q[j] & b0_q[i]) ^ (sgn0_q & ((i == WIDTH-1) != (j == WIDTH-1)));
`else
        pp_flat[i*PW + i + j] = a0_q[j] & b0_q[i];
`endif
      end
    end
`ifdef WALLACE_SIGNED_EN
    pp_flat[WIDTH*PW + WIDTH]  = sgn0_q;
    pp_flat[WIDTH*PW + PW - 1] = sgn0_q;
`endif
  end

  // Wallace levels: rows taken in triples; a leftover pair goes through a
  // half-adder row, a leftover single row passes straight through.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int RIN  = rows_after(NROWS, l);
    localparam int NG   = RIN / 3;
    localparam int REM  = RIN % 3;
    localparam int ROUT = 2 * NG + REM;

    logic [RIN*PW-1:0]  rin;
    logic [ROUT*PW-1:0] rout;

    if (l == 0) begin : g_src
      assign rin = pp_flat;
    end else begin : g_src
      assign rin = g_lvl[l-1].rout;
    end

    for (genvar g = 0; g < NG; g++) begin : g_fa
      wallace_csa_row #(.N(PW)) u_fa (
        .x     (rin[(3*g)*PW +: PW]),
        .y     (rin[(3*g+1)*PW +: PW]),
        .z     (rin[(3*g+2)*PW +: PW]),
        .sum   (rout[(2*g)*PW +: PW]),
        .carry (rout[(2*g+1)*PW +: PW])
      );
    end

    if (REM == 2) begin : g_ha
      wallace_csa_row #(.N(PW)) u_ha (
        .x     (rin[(3*NG)*PW +: PW]),
        .y     (rin[(3*NG+1)*PW +: PW]),
        .z     ({PW{1'b0}}),
        .sum   (rout[(2*NG)*PW +: PW]),
        .carry (rout[(2*NG+1)*PW +: PW])
      );
    end else if (REM == 1) begin : g_pass
      assign rout[(2*NG)*PW +: PW] = rin[(3*NG)*PW +: PW];
    end
  end

  assign red_sum   = g_lvl[LEVELS-1].rout[0 +: PW];
  assign red_carry = g_lvl[LEVELS-1].rout[PW +: PW];

  // Final ripple carry-propagate add; the carry out of the top bit is dropped.
  always_comb begin
    cpa_sum = '0;
    rc      = 1'b0;
    for (int k = 0; k < PW; k++) begin
      cpa_sum[k] = pair_q.sum[k] ^ pair_q.carry[k] ^ rc;
      rc         = (pair_q.sum[k] & pair_q.carry[k]) | (rc & (pair_q.sum[k] ^ pair_q.carry[k]));
    end
  end

  // Columns above PW are always zero in narrower builds.
  assign unused_pair = ^pair_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      out_prod_q <= '0;
      out_tag_q  <= '0;
    end else begin
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      out_prod_q <= out_prod_d;
      out_tag_q  <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    a0_q   <= a0_d;
    b0_q   <= b0_d;
    tag0_q <= tag0_d;
`ifdef WALLACE_SIGNED_EN
    sgn0_q <= sgn0_d;
`endif
    tag1_q <= tag1_d;
    pair_q <= pair_d;
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = v2_q;
  assign io.out_prod  = out_prod_q;
  assign io.out_tag   = out_tag_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb/tb_wallace_mult_pipe.sv - self-checking bench for wallace_mult_pipe (WIDTH=8, TAG_W=4)
module tb_wallace_mult_pipe;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int PW = 2 * W;
  localparam int N_RAND = 2000;

  typedef struct {
    logic [PW-1:0] prod;
    logic [TW-1:0] tag;
    int            acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wallace_mult_pipe_if #(.WIDTH(W), .TAG_W(TW)) io();

  wallace_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  int   n_out  = 0;
  bit   lat_chk = 1'b0;
  logic smp_in_ready;
  logic cur_sg = 1'b0;
  exp_t sb[$];

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    longint x;
    longint y;
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return PW'(x * y);
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t, input logic sg, input logic ordy);
    io.in_valid  = v;
    io.in_a      = a;
    io.in_b      = b;
    io.in_tag    = t;
    io.out_ready = ordy;
    cur_sg       = sg;
`ifdef WALLACE_SIGNED_EN
    io.in_signed = sg;
`endif
  endtask

  // One clock: sample at negedge, score outputs and record accepts, then step past posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    smp_in_ready = io.in_ready;
    if (io.out_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out_valid observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        chk("out_prod", 64'(io.out_prod), 64'(sb[0].prod));
        chk("out_tag", 64'(io.out_tag), 64'(sb[0].tag));
        if (lat_chk && io.out_ready) chk("latency", 64'(cyc - sb[0].acc_cyc), 64'd3);
        if (io.out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
    if (io.in_valid && io.in_ready) begin
      e.prod    = ref_prod(io.in_a, io.in_b, cur_sg);
      e.tag     = io.in_tag;
      e.acc_cyc = cyc;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int sent;
    int guard;
    int pre;
    int acc0;
    int out0;
    bit rv;
    bit rs;

    drive(1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("reset_out_valid", 64'(io.out_valid), 64'd0);
    chk("reset_out_prod", 64'(io.out_prod), 64'd0);
    chk("reset_out_tag", 64'(io.out_tag), 64'd0);
    chk("reset_in_ready", 64'(io.in_ready), 64'd1);

    // Unsigned corners, back-to-back, latency 3 each
    lat_chk = 1'b1;
    out0 = n_out;
    drive(1'b1, 8'd0,   8'd0,   4'd1, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hFF,  8'hFF,  4'd2, 1'b0, 1'b1); tick();
    drive(1'b1, 8'd1,   8'd200, 4'd3, 1'b0, 1'b1); tick();
    drive(1'b0, 8'd0,   8'd0,   4'd0, 1'b0, 1'b1);
    repeat (5) tick();
    chk("corner_count", 64'(n_out - out0), 64'd3);

    // Backpressure: five ops with out_ready low
    lat_chk = 1'b0;
    acc0 = n_acc;
    out0 = n_out;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 8'(17 * (sent + 1)), 8'(sent + 3), 4'(sent + 4), 1'b0, 1'b0);
      pre = n_acc;
      tick();
      if (n_acc != pre) sent++;
    end
    chk("bp_accepted", 64'(n_acc - acc0), 64'd3);
    chk("bp_in_ready_low", 64'(smp_in_ready), 64'd0);
    chk("bp_out_valid", 64'(io.out_valid), 64'd1);
    drive(1'b1, 8'(17 * (sent + 1)), 8'(sent + 3), 4'(sent + 4), 1'b0, 1'b1);
    pre = n_acc;
    tick();
    if (n_acc != pre) sent++;
    chk("bp_restart_ready", 64'(smp_in_ready), 64'd1);
    guard = 0;
    while ((sent < 5 || sb.size() != 0) && guard < 50) begin
      drive(sent < 5, 8'(17 * (sent + 1)), 8'(sent + 3), 4'(sent + 4), 1'b0, 1'b1);
      pre = n_acc;
      tick();
      if (n_acc != pre) sent++;
      guard++;
    end
    chk("bp_drained", 64'(n_out - out0), 64'd5);

    // Bubbles: 13 x 11 every other cycle
    lat_chk = 1'b1;
    out0 = n_out;
    for (int c = 0; c < 12; c++) begin
      drive((c % 2) == 0, 8'd13, 8'd11, 4'(c), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1);
    repeat (5) tick();
    chk("bubble_count", 64'(n_out - out0), 64'd6);

    // Reset with two operations in flight
    drive(1'b1, 8'd9, 8'd7, 4'hA, 1'b0, 1'b1); tick();
    drive(1'b1, 8'd5, 8'd6, 4'hB, 1'b0, 1'b1); tick();
    drive(1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_out_prod", 64'(io.out_prod), 64'd0);
    chk("rst_in_ready", 64'(io.in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out0 = n_out;
    repeat (6) tick();
    chk("rst_no_result", 64'(n_out - out0), 64'd0);

`ifdef WALLACE_SIGNED_EN
    // Signed and unsigned interpretations of the same operands
    out0 = n_out;
    drive(1'b1, 8'h80, 8'h80, 4'd1, 1'b1, 1'b1); tick();
    drive(1'b1, 8'hFF, 8'h01, 4'd2, 1'b1, 1'b1); tick();
    drive(1'b1, 8'h7F, 8'h80, 4'd3, 1'b1, 1'b1); tick();
    drive(1'b1, 8'h80, 8'h80, 4'd4, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hFF, 8'h01, 4'd5, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h7F, 8'h80, 4'd6, 1'b0, 1'b1); tick();
    drive(1'b0, 8'd0, 8'd0, 4'd0, 1'b0, 1'b1);
    repeat (5) tick();
    chk("signed_count", 64'(n_out - out0), 64'd6);
`endif

    // Random sweep with random out_ready
    lat_chk = 1'b0;
    out0 = n_out;
    sent = 0;
    guard = 0;
    while ((sent < N_RAND || sb.size() != 0) && guard < 20000) begin
      rv = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
`ifdef WALLACE_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      drive(rv, 8'($urandom), 8'($urandom), 4'($urandom), rs, $urandom_range(0, 3) != 0);
      pre = n_acc;
      tick();
      if (n_acc != pre) sent++;
      guard++;
    end
    chk("rand_in_time", 64'(guard < 20000), 64'd1);
    chk("rand_count", 64'(n_out - out0), 64'(N_RAND));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wallace_mult_pipe.md
# wallace_mult_pipe

Parametrised, pipelined Wallace-tree multiplier with valid/ready handshakes on input and output. It generalises the team's combinational 8x8 Wallace multiplier to WIDTH-bit operands and inserts pipeline registers between partial-product generation, carry-save reduction and the final carry-propagate add. A TAG field rides alongside each operation. The block sits in the datapath library as the standard integer multiply unit for streaming arithmetic blocks.

## Interface
- WIDTH, 8: operand width in bits; legal range 4..32; product is 2*WIDTH bits.
- TAG_W, 4: width of the sideband tag carried with each operation; legal range 1..16.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and tag valid.
- in_ready  output  1  block can accept this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- in_signed  input  1  present only with WALLACE_SIGNED_EN; 1 selects two's-complement operands.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_prod  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of the operation in out_prod.

## Operation
- Three-stage elastic pipeline:
  - S0: registers operands and tag, then generates the WIDTH×WIDTH AND partial-product array.
  - S1: reduces the array with 3:2 (full-adder) and 2:2 (half-adder) rows, Wallace order, down to two 2*WIDTH rows (sum, carry), then registers them.
  - S2: ripple carry-propagate add of sum and carry, registered into out_prod.
- Each stage has a valid bit v0/v1/v2. A stage loads when the stage downstream is empty or is advancing that cycle.
- in_ready = !v0 | (v0 & (!v1 | adv1)), with adv2 = v2 & out_ready and adv1 = v1 & (!v2 | adv2). Combinational from out_ready, with no combinational path from in_valid to in_ready.
- Accept: in_valid & in_ready. Output transfer: out_valid & out_ready.
- While out_valid=1 and out_ready=0, out_prod and out_tag hold stable and no stage overwrites valid data.
- Width rules:
  - Unsigned product is exact in 2*WIDTH bits, with no truncation or saturation.
  - Carries out of bit 2*WIDTH-1 are discarded; they are always 0 for exact products.
- Tag travels through all three stages in lockstep with its data.
- Reset mid-operation: all in-flight operations are discarded and no partial result is emitted.

## Timing
- Latency: accept in cycle N gives out_valid=1 in cycle N+3 when the pipeline is unstalled.
- Throughput: one operation per cycle while out_ready=1.
- Capacity: up to three operations in flight.
- Full-pipeline stall: v0=v1=v2=1 and out_ready=0 drives in_ready=0. The cycle out_ready rises, in_ready=1 in the same cycle, giving zero-bubble restart.
- Simultaneous accept and output transfer on a full pipeline: both occur, and occupancy stays at 3.
- Reset values: v0=v1=v2=0, out_valid=0, out_prod=0, out_tag=0, in_ready=1 from the first cycle after rst deasserts.
- Data registers other than the outputs are not reset.

## Configuration
- WALLACE_SIGNED_EN defined:
  - Adds the in_signed port, captured per operation in S0 and carried with the data.
  - When in_signed=1, partial products use Baugh-Wooley: MSB-row and MSB-column terms are inverted, and constant 1s are injected at columns WIDTH and 2*WIDTH-1. The result is the exact two's-complement product.
  - When in_signed=0, behaviour is unsigned.
- WALLACE_SIGNED_EN undefined:
  - No in_signed port.
  - Unsigned only, with no Baugh-Wooley logic.
- Latency is identical in both builds.

## Structure
- Shared package wallace_pkg holds:
  - PROD_W(WIDTH) = 2*WIDTH.
  - A function returning the Wallace stage count for a given row count (for WIDTH=8 it gives 4 reduction levels).
  - The typedef for the (sum, carry) row pair.
- Sub-module wallace_csa_row: parametrised N-bit row of full adders, taking three N-bit rows and producing sum and carry (carry shifted by one). It is instantiated per reduction level via generate.
- The half-adder edges are handled inside wallace_csa_row by tying the third input to 0.

## Test plan
- Unsigned corners, WIDTH=8, out_ready=1, back-to-back:
  - 0×0 gives 0x0000.
  - 255×255 gives 0xFE01.
  - 1×200 gives 0x00C8.
  - The three results arrive on consecutive cycles starting 3 cycles after the first accept, with tags 1,2,3 in order.
- Backpressure: stream 5 ops with out_ready=0 from the start.
  - Exactly 3 are accepted, then in_ready=0 and out_prod holds the first result for the whole stall.
  - Releasing out_ready drains all 5 in order with no loss or duplication.
- Bubbles: in_valid toggles every cycle with 13×11.
  - Each result 0x008F appears 3 cycles after its accept, with no spurious out_valid.
- Reset mid-operation: assert rst with 2 ops in flight.
  - out_valid=0, out_prod=0 and in_ready=1 immediately.
  - No result from those ops ever appears.
- Signed mode (WALLACE_SIGNED_EN, WIDTH=8, in_signed=1):
  - 0x80×0x80 gives 0x4000.
  - 0xFF×0x01 gives 0xFFFF.
  - 0x7F×0x80 gives 0xC080.
  - The same operands with in_signed=0 give the unsigned products 0x4000, 0x00FF and 0x3F80.
- Random sweep at WIDTH=4, 8, 16: 10k random operands with random out_ready.
  - Every out_prod equals the reference a*b.
  - Every out_tag matches its operation.
